mcdf_ctrl_regs_gen: RTL

Parametrised register block for the MCDF arbiter/slave front end. It supports NUM_CH slave channels, each with a control register, a low-watermark threshold and a margin status register. Adds a W1C interrupt status, an interrupt enable and error reporting for bad accesses. It sits between the register command bus and the slave/arbiter/formatter blocks, and drives per-channel enable, priority and packet length.

---
 rtl/mcdf_ctrl_regs_gen_pkg.sv | 60 ++++++
 rtl/mcdf_ctrl_regs_gen_if.sv | 22 ++
 rtl/mcdf_ctrl_regs_gen_ch_slice.sv | 69 ++++++
 rtl/mcdf_ctrl_regs_gen.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mcdf_ctrl_regs_gen_pkg.sv
// Shared encodings, register map and address decode for the MCDF
// control register block.
package mcdf_regs_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam logic [31:0] CTRL_BASE     = 32'h00;
  localparam logic [31:0] STAT_BASE     = 32'h20;
  localparam logic [31:0] THRESH_BASE   = 32'h40;
  localparam logic [31:0] INT_STAT_ADDR = 32'h60;
  localparam logic [31:0] INT_EN_ADDR   = 32'h64;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_PRIO_LSB = 1;

  typedef enum logic [2:0] {
    RG_NONE,
    RG_CTRL,
    RG_STAT,
    RG_THRESH,
    RG_INT_STAT,
    RG_INT_EN
  } region_e;

  typedef struct packed {
    region_e    region;
    logic [2:0] ch;
  } dec_t;

  // Per-channel banks are 32 bytes wide; channel index is addr[4:2].
  function automatic dec_t addr_decode(
    input logic [31:0] addr,
    input int          num_ch
  );
    dec_t        d;
    logic [31:0] base;
    logic        ch_ok;
    d.region = RG_NONE;
    d.ch     = addr[4:2];
    base     = {addr[31:5], 5'b0};
    ch_ok    = int'(addr[4:2]) < num_ch;
    if (addr[1:0] == 2'b00) begin
      unique case (1'b1)
        (addr == INT_STAT_ADDR): d.region = RG_INT_STAT;
        (addr == INT_EN_ADDR):   d.region = RG_INT_EN;
        (base == CTRL_BASE):
          if (ch_ok) d.region = RG_CTRL;
        (base == STAT_BASE):
          if (ch_ok) d.region = RG_STAT;
        (base == THRESH_BASE):
          if (ch_ok) d.region = RG_THRESH;
        default: d.region = RG_NONE;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/mcdf_ctrl_regs_gen_if.sv
// Register command bus bundle used to hook a master
// (CPU bridge or bench) to the MCDF register block.
interface mcdf_ctrl_regs_gen_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            cmd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output cmd, addr, wdata,
    input  rdata, err
  );

  modport slave (
    input  cmd, addr, wdata,
    output rdata, err
  );
endinterface

// File: rtl/mcdf_ctrl_regs_gen_ch_slice.sv
// One channel's CTRL/THRESH/STAT registers plus the
// low-watermark edge detector.
module mcdf_reg_ch_slice
  import mcdf_regs_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MARGIN_WIDTH = 8,
  parameter int FIFO_DEPTH   = 32,
  parameter int PRIO_WIDTH   = 2,
  parameter int PKGLEN_WIDTH = 3,
  parameter int THRESH_RST   = 4,
  localparam int CW = 1 + PRIO_WIDTH + PKGLEN_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_ctrl,
  input  logic                    wr_thresh,
  input  logic [CW-1:0]           ctrl_wdata,
  input  logic [MARGIN_WIDTH-1:0] thresh_wdata,
  input  logic [MARGIN_WIDTH-1:0] margin_i,
  output logic                    en_o,
  output logic [PRIO_WIDTH-1:0]   prio_o,
  output logic [PKGLEN_WIDTH-1:0] pkglen_o,
  output logic [DATA_WIDTH-1:0]   ctrl_rd_o,
  output logic [DATA_WIDTH-1:0]   stat_rd_o,
  output logic [DATA_WIDTH-1:0]   thresh_rd_o,
  output logic                    evt_o
);

  localparam int PL_LSB = CTRL_PRIO_LSB + PRIO_WIDTH;
  localparam logic [CW-1:0] CTRL_RST =
    {{PKGLEN_WIDTH{1'b0}}, {PRIO_WIDTH{1'b1}}, 1'b1};

  logic [CW-1:0]           ctrl_q, ctrl_d;
  logic [MARGIN_WIDTH-1:0] thresh_q, thresh_d;
  logic [MARGIN_WIDTH-1:0] stat_q, stat_d;
  logic                    low_q, low_d;

  always_comb begin
    ctrl_d   = wr_ctrl ? ctrl_wdata : ctrl_q;
    thresh_d = wr_thresh ? thresh_wdata : thresh_q;
    stat_d   = margin_i;
    low_d    = stat_q < thresh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= CTRL_RST;
      thresh_q <= MARGIN_WIDTH'(THRESH_RST);
      stat_q   <= MARGIN_WIDTH'(FIFO_DEPTH);
      low_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      thresh_q <= thresh_d;
      stat_q   <= stat_d;
      low_q    <= low_d;
    end
  end

  // Rising edge only: a margin that stays low does not re-fire.
  assign evt_o       = low_d & ~low_q;
  assign en_o        = ctrl_q[CTRL_EN_BIT];
  assign prio_o      = ctrl_q[CTRL_PRIO_LSB +: PRIO_WIDTH];
  assign pkglen_o    = ctrl_q[PL_LSB +: PKGLEN_WIDTH];
  assign ctrl_rd_o   = DATA_WIDTH'(ctrl_q);
  assign stat_rd_o   = DATA_WIDTH'(stat_q);
  assign thresh_rd_o = DATA_WIDTH'(thresh_q);

endmodule

// File: rtl/mcdf_ctrl_regs_gen.sv
// MCDF register block: per-channel slices, W1C interrupt status,
// interrupt enable, read mux and bad-access error pulse.
module mcdf_ctrl_regs_gen
  import mcdf_regs_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int MARGIN_WIDTH = 8,
  parameter int FIFO_DEPTH   = 32,
  parameter int PRIO_WIDTH   = 2,
  parameter int PKGLEN_WIDTH = 3,
  parameter int THRESH_RST   = 4
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [1:0]                     cmd_i,
  input  logic [ADDR_WIDTH-1:0]          cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]          cmd_data_i,
  output logic [DATA_WIDTH-1:0]          cmd_data_o,
  output logic                           cmd_err_o,
  input  logic [NUM_CH*MARGIN_WIDTH-1:0] slv_margin_i,
  output logic [NUM_CH-1:0]              slv_en_o,
  output logic [NUM_CH*PRIO_WIDTH-1:0]   slv_prio_o,
  output logic [NUM_CH*PKGLEN_WIDTH-1:0] slv_pkglen_o,
  output logic                           irq_o
);

  localparam int CW = 1 + PRIO_WIDTH + PKGLEN_WIDTH;

  dec_t dec;
  logic is_rd, is_wr, mapped, wr_ok;

  assign dec    = addr_decode(32'(cmd_addr_i), NUM_CH);
  assign is_rd  = cmd_i == CMD_READ;
  assign is_wr  = cmd_i == CMD_WRITE;
  assign mapped = dec.region != RG_NONE;
  assign wr_ok  = is_wr && mapped && dec.region != RG_STAT;

  logic [NUM_CH-1:0]     wr_ctrl, wr_thresh, evt;
  logic [DATA_WIDTH-1:0] ctrl_rd   [NUM_CH];
  logic [DATA_WIDTH-1:0] stat_rd   [NUM_CH];
  logic [DATA_WIDTH-1:0] thresh_rd [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_ctrl[g] = wr_ok && dec.region == RG_CTRL
                        && dec.ch == 3'(g);
    assign wr_thresh[g] = wr_ok && dec.region == RG_THRESH
                          && dec.ch == 3'(g);

    mcdf_reg_ch_slice #(
      .DATA_WIDTH   (DATA_WIDTH),
      .MARGIN_WIDTH (MARGIN_WIDTH),
      .FIFO_DEPTH   (FIFO_DEPTH),
      .PRIO_WIDTH   (PRIO_WIDTH),
      .PKGLEN_WIDTH (PKGLEN_WIDTH),
      .THRESH_RST   (THRESH_RST)
    ) u_slice (
      .clk          (clk_i),
      .rst_n        (rstn_i),
      .wr_ctrl      (wr_ctrl[g]),
      .wr_thresh    (wr_thresh[g]),
      .ctrl_wdata   (cmd_data_i[CW-1:0]),
      .thresh_wdata (cmd_data_i[MARGIN_WIDTH-1:0]),
      .margin_i     (slv_margin_i[g*MARGIN_WIDTH +: MARGIN_WIDTH]),
      .en_o         (slv_en_o[g]),
      .prio_o       (slv_prio_o[g*PRIO_WIDTH +: PRIO_WIDTH]),
      .pkglen_o     (slv_pkglen_o[g*PKGLEN_WIDTH +: PKGLEN_WIDTH]),
      .ctrl_rd_o    (ctrl_rd[g]),
      .stat_rd_o    (stat_rd[g]),
      .thresh_rd_o  (thresh_rd[g]),
      .evt_o        (evt[g])
    );
  end

  logic [NUM_CH-1:0]     int_stat_q, int_stat_d;
  logic [NUM_CH-1:0]     int_en_q, int_en_d;
  logic [NUM_CH-1:0]     int_clr;
  logic                  irq_q, irq_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] ch_ctrl, ch_stat, ch_thresh, rd_val;

  always_comb begin
    int_clr = '0;
    if (wr_ok && dec.region == RG_INT_STAT)
      int_clr = cmd_data_i[NUM_CH-1:0];
    // A new event on the clearing edge survives the clear.
    int_stat_d = (int_stat_q & ~int_clr) | evt;
    int_en_d   = int_en_q;
    if (wr_ok && dec.region == RG_INT_EN)
      int_en_d = cmd_data_i[NUM_CH-1:0];
    irq_d = |(int_stat_q & int_en_q);

    ch_ctrl   = '0;
    ch_stat   = '0;
    ch_thresh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (dec.ch == 3'(i)) begin
        ch_ctrl   = ctrl_rd[i];
        ch_stat   = stat_rd[i];
        ch_thresh = thresh_rd[i];
      end
    end

    rd_val = '0;
    unique case (dec.region)
      RG_CTRL:     rd_val = ch_ctrl;
      RG_STAT:     rd_val = ch_stat;
      RG_THRESH:   rd_val = ch_thresh;
      RG_INT_STAT: rd_val = DATA_WIDTH'(int_stat_q);
      RG_INT_EN:   rd_val = DATA_WIDTH'(int_en_q);
      default:     rd_val = '0;
    endcase

    rdata_d = is_rd ? rd_val : rdata_q;
    err_d   = (is_rd && !mapped) || (is_wr && !wr_ok);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      int_stat_q <= '0;
      int_en_q   <= '0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      int_stat_q <= int_stat_d;
      int_en_q   <= int_en_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign cmd_data_o = rdata_q;
  assign cmd_err_o  = err_q;
  assign irq_o      = irq_q;

endmodule
